lcd_hd44780_model: RTL and testbench

Synthesisable, cycle-accurate responder for the HD44780 character-LCD bus as driven by the 65c02 SoC's VIA (port B = data, port A[7:5] = E/RW/RS). It is the parametrised successor to the fixed busy-flag stub in the CPU benches. It decodes commands and data, keeps a 128-byte DDRAM and address counter, and models a programmable busy flag. It also supports 8-bit and 4-bit interface modes and logs every completed write into a capture FIFO for self-checking benches.

---
 rtl/lcd_hd44780_model.sv | 270 +++++++++++++++++++++++++++
 tb/tb_lcd_hd44780_model.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_hd44780_model.sv
// Small ring-buffer FIFO used for the write-capture log.
// Latency: a push is visible at the head on the next cycle; a pop takes effect on the next edge.
// Backpressure: in_rdy drops when full unless the head is popped in the same cycle.
module lcd_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 16
) (
    input  logic         core_clk,
    input  logic         arst_n,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    output logic         in_rdy,
    output logic         out_vld,
    output logic [W-1:0] out_dat,
    input  logic         out_rdy
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign out_vld = (count != '0);
    assign in_rdy  = (count != (AW+1)'(DEPTH)) | out_rdy;
    assign out_dat = mem[rd_ptr];
    assign do_push = in_vld & in_rdy;
    assign do_pop  = out_vld & out_rdy;

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // When full, wr_ptr == rd_ptr: a simultaneous push overwrites the slot being popped.
    always_ff @(posedge core_clk) begin
        if (do_push) mem[wr_ptr] <= in_dat;
    end
endmodule

// HD44780 bus responder: command/data decode, 128-byte DDRAM, busy flag, 4/8-bit modes, write log.
// Latency: write effects one edge after E falls; read data driven one edge after the rise is seen.
// Backpressure: writes while busy are dropped (err); writes into a full log are dropped (cap_overflow).
module lcd_hd44780_model #(
    parameter int BUSY_CYCLES      = 50,
    parameter int LONG_BUSY_CYCLES = 200,
    parameter int FIFO_DEPTH       = 16
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       lcd_e,
    input  logic       lcd_rw,
    input  logic       lcd_rs,
    input  logic [7:0] db_in,
    output logic [7:0] db_out,
    output logic       db_oe,
    output logic       busy,
    output logic [6:0] ac,
    output logic       four_bit,
    output logic       cap_valid,
    output logic [8:0] cap_data,
    input  logic       cap_ready,
    output logic       cap_overflow,
    output logic       err
);
    localparam int BMAX = (LONG_BUSY_CYCLES > BUSY_CYCLES) ? LONG_BUSY_CYCLES : BUSY_CYCLES;
    localparam int BW   = $clog2(BMAX + 1);

    typedef enum logic [2:0] {CMD_NONE, CMD_CLEAR, CMD_HOME, CMD_ENTRY, CMD_FSET, CMD_ADDR} cmd_t;

    logic [7:0]    ddram [128];
    logic          e_q, rise, fall;
    logic          rs_l, rw_l;
    logic [7:0]    db_l;
    logic          nib_phase, first_rs, first_rw;
    logic [3:0]    hi_nib;
    logic          inc;
    logic [BW-1:0] busy_cnt;
    logic          clr_active;
    logic [6:0]    clr_addr;
    logic          rd_go, fall_d;
    logic [7:0]    rd_nxt, rd_word, rd_sample;
    logic          xfer_done, xfer_rs, xfer_rw, pair_err;
    logic [7:0]    xfer_byte;
    logic          wr_commit, wr_reject, rd_step;
    logic [6:0]    ac_step;
    logic          fifo_in_rdy;
    cmd_t          cmd;

    assign rise      = lcd_e & ~e_q;
    assign fall      = ~lcd_e & e_q;
    assign busy      = (busy_cnt != '0);
    assign rd_sample = lcd_rs ? ddram[ac] : {busy, ac};
    assign ac_step   = inc ? ac + 7'd1 : ac - 7'd1;

    always_comb begin
        xfer_done = 1'b0;
        pair_err  = 1'b0;
        xfer_rs   = rs_l;
        xfer_rw   = rw_l;
        xfer_byte = db_l;
        if (fall) begin
            if (!four_bit) begin
                xfer_done = 1'b1;
            end else if (nib_phase) begin
                if (rs_l != first_rs || rw_l != first_rw) begin
                    pair_err = 1'b1;
                end else begin
                    xfer_done = 1'b1;
                    xfer_byte = {hi_nib, db_l[7:4]};
                end
            end
        end
        wr_commit = xfer_done & ~xfer_rw & ~busy;
        wr_reject = xfer_done & ~xfer_rw & busy;
        rd_step   = xfer_done & xfer_rw & xfer_rs;

        // Instruction class is chosen by the highest set bit.
        cmd = CMD_NONE;
        if (!xfer_rs) begin
            priority casez (xfer_byte)
                8'b1???????: cmd = CMD_ADDR;
                8'b01??????: cmd = CMD_NONE;
                8'b001?????: cmd = CMD_FSET;
                8'b0001????: cmd = CMD_NONE;
                8'b00001???: cmd = CMD_NONE;
                8'b000001??: cmd = CMD_ENTRY;
                8'b0000001?: cmd = CMD_HOME;
                8'b00000001: cmd = CMD_CLEAR;
                default:     cmd = CMD_NONE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            e_q          <= 1'b0;
            rs_l         <= 1'b0;
            rw_l         <= 1'b0;
            db_l         <= '0;
            nib_phase    <= 1'b0;
            first_rs     <= 1'b0;
            first_rw     <= 1'b0;
            hi_nib       <= '0;
            inc          <= 1'b1;
            busy_cnt     <= '0;
            clr_active   <= 1'b0;
            clr_addr     <= '0;
            rd_go        <= 1'b0;
            fall_d       <= 1'b0;
            rd_nxt       <= '0;
            rd_word      <= '0;
            db_out       <= '0;
            db_oe        <= 1'b0;
            ac           <= '0;
            four_bit     <= 1'b0;
            cap_overflow <= 1'b0;
            err          <= 1'b0;
        end else begin
            e_q <= lcd_e;
            if (lcd_e) begin
                rs_l <= lcd_rs;
                rw_l <= lcd_rw;
                db_l <= db_in;
            end

            // Read data is sampled on the rise and driven one cycle later.
            fall_d <= fall;
            rd_go  <= rise & lcd_rw;
            if (rise && lcd_rw) begin
                if (!four_bit) begin
                    rd_nxt <= rd_sample;
                end else if (!nib_phase) begin
                    rd_word <= rd_sample;
                    rd_nxt  <= {rd_sample[7:4], 4'h0};
                end else begin
                    rd_nxt <= {rd_word[3:0], 4'h0};
                end
            end
            if (rd_go) begin
                db_oe  <= 1'b1;
                db_out <= rd_nxt;
            end else if (fall_d) begin
                db_oe <= 1'b0;
            end

            if (fall && four_bit) begin
                if (!nib_phase) begin
                    nib_phase <= 1'b1;
                    hi_nib    <= db_l[7:4];
                    first_rs  <= rs_l;
                    first_rw  <= rw_l;
                end else begin
                    nib_phase <= 1'b0;
                end
            end

            if (pair_err || wr_reject) err <= 1'b1;
            if (wr_commit && !fifo_in_rdy) cap_overflow <= 1'b1;

            if (clr_active) begin
                clr_addr <= clr_addr + 7'd1;
                if (clr_addr == 7'h7F) clr_active <= 1'b0;
            end

            if (wr_commit)
                busy_cnt <= (cmd == CMD_CLEAR || cmd == CMD_HOME) ? BW'(LONG_BUSY_CYCLES)
                                                                  : BW'(BUSY_CYCLES);
            else if (busy)
                busy_cnt <= busy_cnt - BW'(1);

            if (wr_commit) begin
                if (xfer_rs) begin
                    ac <= ac_step;
                end else begin
                    case (cmd)
                        CMD_CLEAR: begin
                            ac         <= '0;
                            inc        <= 1'b1;
                            clr_active <= 1'b1;
                            clr_addr   <= '0;
                        end
                        CMD_HOME:  ac  <= '0;
                        CMD_ENTRY: inc <= xfer_byte[1];
                        CMD_FSET: begin
                            four_bit  <= ~xfer_byte[4];
                            nib_phase <= 1'b0;
                        end
                        CMD_ADDR:  ac  <= xfer_byte[6:0];
                        default:   ;
                    endcase
                end
            end else if (rd_step) begin
                ac <= ac_step;
            end
        end
    end

    // Clear walks one address per cycle while the long busy time hides it from the CPU.
    always_ff @(posedge clk) begin
        if (clr_active)
            ddram[clr_addr] <= 8'h20;
        else if (wr_commit && xfer_rs)
            ddram[ac] <= xfer_byte;
    end

    lcd_fifo #(.W(9), .DEPTH(FIFO_DEPTH)) u_cap_fifo (
        .core_clk (clk),
        .arst_n   (RST),
        .in_vld   (wr_commit),
        .in_dat   ({xfer_rs, xfer_byte}),
        .in_rdy   (fifo_in_rdy),
        .out_vld  (cap_valid),
        .out_dat  (cap_data),
        .out_rdy  (cap_ready)
    );
endmodule

// File: tb/tb_lcd_hd44780_model.sv
// Directed bench for lcd_hd44780_model: 8/4-bit writes and reads, busy timing, clear, errors, capture FIFO.
module tb_lcd_hd44780_model;
    logic       clk = 1'b0;
    logic       RST;
    logic       lcd_e, lcd_rw, lcd_rs;
    logic [7:0] db_in;
    logic [7:0] db_out;
    logic       db_oe, busy, four_bit, cap_valid, cap_ready, cap_overflow, err;
    logic [6:0] ac;
    logic [8:0] cap_data;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int cm;
    int bad;
    logic [7:0] rd;
    logic       oe;
    logic [31:0] want;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lcd_hd44780_model dut (
        .clk          (clk),
        .RST          (RST),
        .lcd_e        (lcd_e),
        .lcd_rw       (lcd_rw),
        .lcd_rs       (lcd_rs),
        .db_in        (db_in),
        .db_out       (db_out),
        .db_oe        (db_oe),
        .busy         (busy),
        .ac           (ac),
        .four_bit     (four_bit),
        .cap_valid    (cap_valid),
        .cap_data     (cap_data),
        .cap_ready    (cap_ready),
        .cap_overflow (cap_overflow),
        .err          (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // One E pulse; read data sampled mid-pulse; returns just after the edge that sees the fall.
    task automatic bus(input logic rs, input logic rw, input logic [7:0] d, input logic pop,
                       output logic [7:0] rdv, output logic oev);
        @(posedge clk); #1;
        lcd_rs = rs; lcd_rw = rw; db_in = d; lcd_e = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rdv = db_out;
        oev = db_oe;
        @(posedge clk); #1;
        lcd_e = 1'b0;
        if (pop) cap_ready = 1'b1;
        @(posedge clk); #1;
        if (pop) cap_ready = 1'b0;
    endtask

    task automatic wr(input logic rs, input logic [7:0] d);
        bus(rs, 1'b0, d, 1'b0, rd, oe);
    endtask

    task automatic rdx(input logic rs);
        bus(rs, 1'b1, 8'h00, 1'b0, rd, oe);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", 32'(busy), 0);
    endtask

    task automatic pulse_reset();
        RST = 1'b0;
        #1;
        @(posedge clk); #1;
        RST = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b0; lcd_e = 1'b0; lcd_rw = 1'b0; lcd_rs = 1'b0; db_in = 8'h00; cap_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_db_out", 32'(db_out), 0);
        chk("rst_db_oe", 32'(db_oe), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ac", 32'(ac), 0);
        chk("rst_four_bit", 32'(four_bit), 0);
        chk("rst_cap_valid", 32'(cap_valid), 0);
        chk("rst_overflow", 32'(cap_overflow), 0);
        chk("rst_err", 32'(err), 0);
        RST = 1'b1;

        // 8-bit function set, exact short busy window
        wr(1'b0, 8'h38);
        chk("fs38_cap", 32'(cap_data), 'h038);
        chk("fs38_capv", 32'(cap_valid), 1);
        chk("fs38_busy", 32'(busy), 1);
        chk("fs38_8bit", 32'(four_bit), 0);
        chk("fs38_oe", 32'(oe), 0);
        repeat (49) @(posedge clk);
        #1 chk("busy_last_cycle", 32'(busy), 1);
        @(posedge clk);
        #1 chk("busy_released", 32'(busy), 0);

        wr(1'b1, 8'h41);
        chk("d41_cap", 32'(cap_data), 'h141);
        chk("d41_ac", 32'(ac), 1);
        wait_idle();
        wr(1'b0, 8'h80);
        chk("addr80_ac", 32'(ac), 0);
        wait_idle();
        rdx(1'b1);
        chk("rd_ddram0", 32'(rd), 'h41);
        chk("rd_oe", 32'(oe), 1);
        chk("rd_ac_step", 32'(ac), 1);
        chk("rd_no_push", 32'(cap_valid), 0);
        @(posedge clk);
        #1 chk("rd_oe_release", 32'(db_oe), 0);

        // Clear: status read during long busy, then exact release and filled DDRAM
        wr(1'b0, 8'h01);
        cm = cyc;
        chk("clr_ac", 32'(ac), 0);
        rdx(1'b0);
        chk("clr_status_busy", 32'(rd), 'h80);
        chk("clr_status_oe", 32'(oe), 1);
        chk("clr_no_err", 32'(err), 0);
        while (cyc < cm + 199) begin @(posedge clk); #1; end
        chk("long_busy_last", 32'(busy), 1);
        @(posedge clk);
        #1 chk("long_busy_release", 32'(busy), 0);
        rdx(1'b0);
        chk("clr_status_idle", 32'(rd), 'h00);
        bad = 0;
        for (int i = 0; i < 128; i++) begin
            rdx(1'b1);
            if (rd !== 8'h20) bad++;
        end
        chk("ddram_cleared", 32'(bad), 0);
        chk("ac_wrap_up", 32'(ac), 0);

        // Decrement mode wraps below zero
        wr(1'b0, 8'h04);
        wait_idle();
        wr(1'b0, 8'h80);
        wait_idle();
        wr(1'b1, 8'h5A);
        chk("dec_wrap_ac", 32'(ac), 'h7F);
        chk("dec_cap", 32'(cap_data), 'h15A);
        wait_idle();
        wr(1'b0, 8'h80);
        wait_idle();
        rdx(1'b1);
        chk("rd_5a", 32'(rd), 'h5A);
        chk("rd_dec_ac", 32'(ac), 'h7F);

        // Write while busy is dropped and flagged
        wr(1'b0, 8'h06);
        wr(1'b1, 8'h77);
        chk("busy_wr_err", 32'(err), 1);
        chk("busy_wr_nopush", 32'(cap_valid), 0);
        chk("busy_wr_ac", 32'(ac), 'h7F);
        wait_idle();
        rdx(1'b1);
        chk("busy_wr_ddram", 32'(rd), 'h20);
        chk("inc_wrap_ac", 32'(ac), 0);

        // 4-bit interface
        wr(1'b0, 8'h28);
        chk("fs28_four", 32'(four_bit), 1);
        chk("fs28_cap", 32'(cap_data), 'h028);
        wait_idle();
        wr(1'b0, 8'h80);
        wr(1'b0, 8'h00);
        chk("nib_addr_cap", 32'(cap_data), 'h080);
        wait_idle();
        wr(1'b1, 8'h40);
        chk("nib_half_nopush", 32'(cap_valid), 0);
        wr(1'b1, 8'h80);
        chk("nib_data_cap", 32'(cap_data), 'h148);
        chk("nib_data_ac", 32'(ac), 1);
        wait_idle();
        rdx(1'b0);
        chk("nib_status_hi", 32'(rd), 'h00);
        rdx(1'b0);
        chk("nib_status_lo", 32'(rd), 'h10);
        chk("nib_status_oe", 32'(oe), 1);
        wr(1'b0, 8'h80);
        wr(1'b0, 8'h00);
        wait_idle();
        rdx(1'b1);
        chk("nib_rd_hi", 32'(rd), 'h40);
        rdx(1'b1);
        chk("nib_rd_lo", 32'(rd), 'h80);
        chk("nib_rd_ac", 32'(ac), 1);

        // Reset in the middle of a nibble pair
        wr(1'b1, 8'h30);
        RST = 1'b0;
        #1;
        chk("midrst_four", 32'(four_bit), 0);
        chk("midrst_ac", 32'(ac), 0);
        chk("midrst_err", 32'(err), 0);
        @(posedge clk); #1;
        RST = 1'b1;

        // Nibble pair with mismatched rs is discarded; the next pair realigns
        wr(1'b0, 8'h28);
        wait_idle();
        wr(1'b1, 8'h40);
        wr(1'b0, 8'h10);
        chk("mismatch_err", 32'(err), 1);
        chk("mismatch_nopush", 32'(cap_valid), 0);
        wr(1'b1, 8'h40);
        wr(1'b1, 8'h20);
        chk("realign_cap", 32'(cap_data), 'h142);
        wait_idle();

        // Capture FIFO overflow
        pulse_reset();
        cap_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr(1'b1, 8'(16 + i));
            wait_idle();
        end
        chk("full_no_ovf", 32'(cap_overflow), 0);
        chk("full_head", 32'(cap_data), 'h110);
        wr(1'b1, 8'h2F);
        chk("ovf_set", 32'(cap_overflow), 1);
        wait_idle();

        // Push and pop on the same edge while full
        pulse_reset();
        for (int i = 0; i < 16; i++) begin
            wr(1'b1, 8'(16 + i));
            wait_idle();
        end
        bus(1'b1, 1'b0, 8'h3C, 1'b1, rd, oe);
        chk("pushpop_no_ovf", 32'(cap_overflow), 0);
        chk("pushpop_head", 32'(cap_data), 'h111);
        cap_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            want = (i < 15) ? 32'('h111 + i) : 32'h13C;
            if (32'(cap_data) !== want || cap_valid !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        chk("drain_order", 32'(bad), 0);
        chk("drain_empty", 32'(cap_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
